hierarchy_request_arbiter: RTL and testbench

//  N-port arbiter between NUM_PORTS upper-level cache request channels (msg/address/line data) and one lower-level

---
 rtl/hierarchy_request_arbiter_if.sv | 35 +++
 rtl/hierarchy_request_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_hierarchy_request_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hierarchy_request_arbiter_if.sv
// rtl/hierarchy_request_arbiter_if.sv - upper-level request/response channels plus the lower-level channel
// Per-port fields are packed side by side, port p at [p*WIDTH +: WIDTH].
interface hierarchy_request_arbiter_if #(
   parameter int NUM_PORTS     = 4,
   parameter int MSG_BITS      = 3,
   parameter int ADDRESS_WIDTH = 32,
   parameter int BUS_WIDTH     = 132
);
   logic [NUM_PORTS*MSG_BITS-1:0]      req_msg;
   logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_address;
   logic [NUM_PORTS*BUS_WIDTH-1:0]     req_data;
   logic [NUM_PORTS*MSG_BITS-1:0]      resp_msg;
   logic [NUM_PORTS*ADDRESS_WIDTH-1:0] resp_address;
   logic [NUM_PORTS*BUS_WIDTH-1:0]     resp_data;
   logic [MSG_BITS-1:0]                down_msg_out;
   logic [ADDRESS_WIDTH-1:0]           down_address_out;
   logic [BUS_WIDTH-1:0]               down_data_out;
   logic [MSG_BITS-1:0]                down_msg_in;
   logic [ADDRESS_WIDTH-1:0]           down_address_in;
   logic [BUS_WIDTH-1:0]               down_data_in;

   modport slave (
      input  req_msg, req_address, req_data,
      input  down_msg_in, down_address_in, down_data_in,
      output resp_msg, resp_address, resp_data,
      output down_msg_out, down_address_out, down_data_out
   );

   modport master (
      output req_msg, req_address, req_data,
      output down_msg_in, down_address_in, down_data_in,
      input  resp_msg, resp_address, resp_data,
      input  down_msg_out, down_address_out, down_data_out
   );
endinterface

// File: rtl/hierarchy_request_arbiter.sv
// rtl/hierarchy_request_arbiter.sv - round-robin arbiter of N cache request ports onto one lower-level channel
// One transaction in flight: IDLE grants, BUSY waits for the lower level, DRAIN waits for the winner to withdraw.
module hierarchy_request_arbiter #(
   parameter int NUM_PORTS      = 4,
   parameter int MSG_BITS       = 3,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int BUS_WIDTH      = 132,
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int ID_BITS        = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   hierarchy_request_arbiter_if.slave bus,
   output logic [ID_BITS-1:0]         grant_id,
   output logic                       busy,
   output logic                       timeout_err
);
   localparam int TIMER_BITS = $clog2(TIMEOUT_CYCLES + 1);
   localparam int MSG_ALL    = NUM_PORTS * MSG_BITS;
   localparam int ADDR_ALL   = NUM_PORTS * ADDRESS_WIDTH;
   localparam int DATA_ALL   = NUM_PORTS * BUS_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ID_BITS-1:0]      r_last_grant, w_last_nxt;
   logic [ID_BITS-1:0]      r_grant_id, w_grant_nxt;
   logic                    r_busy, w_busy_nxt;
   logic                    r_timeout_err, w_err_nxt;
   logic [TIMER_BITS-1:0]   r_timer, w_timer_nxt;
   logic [MSG_BITS-1:0]     r_down_msg, w_down_msg_nxt;
   logic [ADDRESS_WIDTH-1:0] r_down_address, w_down_address_nxt;
   logic [BUS_WIDTH-1:0]    r_down_data, w_down_data_nxt;
   logic [MSG_ALL-1:0]      r_resp_msg, w_resp_msg_nxt;
   logic [ADDR_ALL-1:0]     r_resp_address, w_resp_address_nxt;
   logic [DATA_ALL-1:0]     r_resp_data, w_resp_data_nxt;

   logic [NUM_PORTS-1:0]    w_req_vec;
   logic                    w_any_req;
   logic                    w_found;
   logic [ID_BITS-1:0]      w_scan_idx;
   logic [ID_BITS-1:0]      w_winner;
   logic [MSG_BITS-1:0]     w_win_msg;
   logic [ADDRESS_WIDTH-1:0] w_win_address;
   logic [BUS_WIDTH-1:0]    w_win_data;
   logic                    w_grant_req;
   logic                    w_resp_valid;
   logic                    w_timer_expired;

   always_comb begin
      w_req_vec = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_req_vec[p] = |bus.req_msg[p*MSG_BITS +: MSG_BITS];
      end
   end

   assign w_any_req = |w_req_vec;

   // Scan starts just after the previous owner, so the last winner has the lowest priority.
   always_comb begin
      w_found    = 1'b0;
      w_winner   = '0;
      w_scan_idx = '0;
      for (int off = 1; off <= NUM_PORTS; off++) begin
         w_scan_idx = ID_BITS'((int'(r_last_grant) + off) % NUM_PORTS);
         if (!w_found && w_req_vec[w_scan_idx]) begin
            w_found  = 1'b1;
            w_winner = w_scan_idx;
         end
      end
   end

   assign w_win_msg       = bus.req_msg[int'(w_winner)*MSG_BITS +: MSG_BITS];
   assign w_win_address   = bus.req_address[int'(w_winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
   assign w_win_data      = bus.req_data[int'(w_winner)*BUS_WIDTH +: BUS_WIDTH];
   assign w_grant_req     = |bus.req_msg[int'(r_grant_id)*MSG_BITS +: MSG_BITS];
   assign w_resp_valid    = (bus.down_msg_in != '0);
   assign w_timer_expired = (r_timer == TIMER_BITS'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_state_nxt        = r_state;
      w_last_nxt         = r_last_grant;
      w_grant_nxt        = r_grant_id;
      w_busy_nxt         = r_busy;
      w_err_nxt          = r_timeout_err;
      w_timer_nxt        = r_timer;
      w_down_msg_nxt     = r_down_msg;
      w_down_address_nxt = r_down_address;
      w_down_data_nxt    = r_down_data;
      w_resp_msg_nxt     = r_resp_msg;
      w_resp_address_nxt = r_resp_address;
      w_resp_data_nxt    = r_resp_data;

      case (r_state)
         S_IDLE: begin
            w_down_msg_nxt     = '0;
            w_down_address_nxt = '0;
            w_down_data_nxt    = '0;
            w_resp_msg_nxt     = '0;
            w_resp_address_nxt = '0;
            w_resp_data_nxt    = '0;
            if (w_any_req) begin
               w_down_msg_nxt     = w_win_msg;
               w_down_address_nxt = w_win_address;
               w_down_data_nxt    = w_win_data;
               w_grant_nxt        = w_winner;
               w_busy_nxt         = 1'b1;
               w_timer_nxt        = '0;
               w_state_nxt        = S_BUSY;
            end
         end

         S_BUSY: begin
            // A response arriving on the expiry cycle still completes normally.
            if (w_resp_valid) begin
               w_resp_msg_nxt     = '0;
               w_resp_address_nxt = '0;
               w_resp_data_nxt    = '0;
               w_resp_msg_nxt[int'(r_grant_id)*MSG_BITS +: MSG_BITS]                = bus.down_msg_in;
               w_resp_address_nxt[int'(r_grant_id)*ADDRESS_WIDTH +: ADDRESS_WIDTH] = bus.down_address_in;
               w_resp_data_nxt[int'(r_grant_id)*BUS_WIDTH +: BUS_WIDTH]             = bus.down_data_in;
               w_down_msg_nxt     = '0;
               w_down_address_nxt = '0;
               w_down_data_nxt    = '0;
               w_state_nxt        = S_DRAIN;
            end else if (w_timer_expired) begin
               w_down_msg_nxt     = '0;
               w_down_address_nxt = '0;
               w_down_data_nxt    = '0;
               w_err_nxt          = 1'b1;
               w_last_nxt         = r_grant_id;
               w_busy_nxt         = 1'b0;
               w_state_nxt        = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + TIMER_BITS'(1);
            end
         end

         S_DRAIN: begin
            if (!w_grant_req) begin
               w_resp_msg_nxt     = '0;
               w_resp_address_nxt = '0;
               w_resp_data_nxt    = '0;
               w_last_nxt         = r_grant_id;
               w_busy_nxt         = 1'b0;
               w_state_nxt        = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_last_grant   <= ID_BITS'(NUM_PORTS - 1);
         r_grant_id     <= '0;
         r_busy         <= 1'b0;
         r_timeout_err  <= 1'b0;
         r_timer        <= '0;
         r_down_msg     <= '0;
         r_down_address <= '0;
         r_down_data    <= '0;
         r_resp_msg     <= '0;
         r_resp_address <= '0;
         r_resp_data    <= '0;
      end else begin
         r_last_grant   <= w_last_nxt;
         r_grant_id     <= w_grant_nxt;
         r_busy         <= w_busy_nxt;
         r_timeout_err  <= w_err_nxt;
         r_timer        <= w_timer_nxt;
         r_down_msg     <= w_down_msg_nxt;
         r_down_address <= w_down_address_nxt;
         r_down_data    <= w_down_data_nxt;
         r_resp_msg     <= w_resp_msg_nxt;
         r_resp_address <= w_resp_address_nxt;
         r_resp_data    <= w_resp_data_nxt;
      end
   end

   assign bus.down_msg_out     = r_down_msg;
   assign bus.down_address_out = r_down_address;
   assign bus.down_data_out    = r_down_data;
   assign bus.resp_msg         = r_resp_msg;
   assign bus.resp_address     = r_resp_address;
   assign bus.resp_data        = r_resp_data;
   assign grant_id             = r_grant_id;
   assign busy                 = r_busy;
   assign timeout_err          = r_timeout_err;
endmodule

// File: tb/tb_hierarchy_request_arbiter.sv
// tb/tb_hierarchy_request_arbiter.sv - randomized self-checking bench for hierarchy_request_arbiter
// A 4-port instance carries most scenarios; a 2-port instance checks strict alternation.
module tb_hierarchy_request_arbiter;
   localparam int NP = 4;
   localparam int MB = 3;
   localparam int AW = 32;
   localparam int BW = 132;
   localparam int TO = 8;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   m_last;

   logic [1:0] grant_id;
   logic       busy;
   logic       timeout_err;
   logic       g2_id;
   logic       g2_busy;
   logic       g2_err;

   hierarchy_request_arbiter_if #(.NUM_PORTS(NP), .MSG_BITS(MB), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus ();
   hierarchy_request_arbiter_if #(.NUM_PORTS(2), .MSG_BITS(MB), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus2 ();

   hierarchy_request_arbiter #(.NUM_PORTS(NP), .MSG_BITS(MB), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW),
                               .TIMEOUT_CYCLES(TO), .ID_BITS(2)) u_dut (
      .clock(clock), .reset(reset), .bus(bus.slave),
      .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
   );

   hierarchy_request_arbiter #(.NUM_PORTS(2), .MSG_BITS(MB), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW),
                               .TIMEOUT_CYCLES(TO), .ID_BITS(1)) u_dut2 (
      .clock(clock), .reset(reset), .bus(bus2.slave),
      .grant_id(g2_id), .busy(g2_busy), .timeout_err(g2_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [BW-1:0] rand_line();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[BW-1:0];
   endfunction

   task automatic set_req(input int p, input logic [MB-1:0] m, input logic [AW-1:0] a, input logic [BW-1:0] d);
      bus.req_msg[p*MB +: MB]     = m;
      bus.req_address[p*AW +: AW] = a;
      bus.req_data[p*BW +: BW]    = d;
   endtask

   function automatic logic [NP-1:0] req_mask();
      logic [NP-1:0] m;
      for (int p = 0; p < NP; p++) m[p] = (bus.req_msg[p*MB +: MB] != '0);
      return m;
   endfunction

   // Reference rule: nearest requesting port strictly after the previous owner, wrapping.
   function automatic int rr_pick(input int last, input logic [NP-1:0] mask);
      for (int k = 1; k <= NP; k++) begin
         if (mask[(last + k) % NP]) return (last + k) % NP;
      end
      return -1;
   endfunction

   task automatic clear_inputs();
      bus.req_msg = '0;  bus.req_address = '0;  bus.req_data = '0;
      bus.down_msg_in = '0;  bus.down_address_in = '0;  bus.down_data_in = '0;
      bus2.req_msg = '0; bus2.req_address = '0; bus2.req_data = '0;
      bus2.down_msg_in = '0; bus2.down_address_in = '0; bus2.down_data_in = '0;
   endtask

   task automatic reset_dut();
      clear_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      m_last = NP - 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if ({busy, timeout_err, grant_id} !== 4'b0 || bus.down_msg_out !== '0 || bus.down_address_out !== '0 ||
          bus.down_data_out !== '0 || bus.resp_msg !== '0 || bus.resp_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%0b err=%0b gid=%0d down_msg=%0h resp_msg=%0h, want all 0",
                  busy, timeout_err, grant_id, bus.down_msg_out, bus.resp_msg);
      end
      checks++;
      if ({g2_busy, g2_err, g2_id} !== 3'b0 || bus2.down_msg_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs_2port: busy=%0b err=%0b gid=%0d, want 0", g2_busy, g2_err, g2_id);
      end
      reset = 1'b1;
      m_last = NP - 1;
   endtask

   task automatic test_single_read();
      logic [BW-1:0]      line;
      logic [NP*MB-1:0]   e_msg;
      logic [NP*AW-1:0]   e_addr;
      logic [NP*BW-1:0]   e_data;
      line = {{16{8'hA5}}, 4'hA};
      set_req(2, 3'd1, 32'h40, rand_line());
      tick();
      checks++;
      if (bus.down_msg_out !== 3'd1 || bus.down_address_out !== 32'h40 || grant_id !== 2'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: msg=%0h addr=%0h gid=%0d busy=%0b, want 1/40/2/1",
                  bus.down_msg_out, bus.down_address_out, grant_id, busy);
      end
      bus.down_msg_in = 3'd4; bus.down_address_in = 32'h40; bus.down_data_in = line;
      tick();
      bus.down_msg_in = '0;
      e_msg = '0;  e_msg[2*MB +: MB] = 3'd4;
      e_addr = '0; e_addr[2*AW +: AW] = 32'h40;
      e_data = '0; e_data[2*BW +: BW] = line;
      checks++;
      if (bus.resp_msg !== e_msg || bus.resp_address !== e_addr || bus.resp_data !== e_data || bus.down_msg_out !== '0) begin
         errors++;
         $display("FAIL single_resp: resp_msg=%0h down_msg=%0h, want %0h/0", bus.resp_msg, bus.down_msg_out, e_msg);
      end
      bus.req_msg[2*MB +: MB] = '0;
      tick();
      checks++;
      if (bus.resp_msg !== '0 || bus.resp_data !== '0 || busy !== 1'b0 || grant_id !== 2'd2) begin
         errors++;
         $display("FAIL single_release: resp_msg=%0h busy=%0b gid=%0d, want 0/0/2", bus.resp_msg, busy, grant_id);
      end
      m_last = 2;
   endtask

   task automatic test_round_robin();
      int order [4];
      order = '{0, 1, 3, 0};
      reset_dut();
      set_req(0, 3'd1, 32'h1000, rand_line());
      set_req(1, 3'd2, 32'h1001, rand_line());
      set_req(3, 3'd4, 32'h1003, rand_line());
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (grant_id !== 2'(order[i]) || bus.down_address_out !== 32'h1000 + order[i]) begin
            errors++;
            $display("FAIL rr_grant[%0d]: gid=%0d addr=%0h, want %0d", i, grant_id, bus.down_address_out, order[i]);
         end
         bus.down_msg_in = 3'd6;
         tick();
         bus.down_msg_in = '0;
         bus.req_msg[order[i]*MB +: MB] = '0;
         tick();
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_release[%0d]: busy=%0b, want 0", i, busy);
         end
         bus.req_msg[order[i]*MB +: MB] = 3'd2;
      end
   endtask

   task automatic test_isolation();
      logic [BW-1:0] d1;
      reset_dut();
      d1 = rand_line();
      set_req(1, 3'd3, 32'hBEEF, d1);
      tick();
      checks++;
      if (grant_id !== 2'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL iso_grant: gid=%0d busy=%0b, want 1/1", grant_id, busy);
      end
      for (int i = 0; i < 3; i++) begin
         set_req(0, 3'($urandom_range(1, 7)), $urandom, rand_line());
         bus.req_address[AW +: AW] = $urandom;
         tick();
         checks++;
         if (bus.down_msg_out !== 3'd3 || bus.down_address_out !== 32'hBEEF || bus.down_data_out !== d1 ||
             bus.resp_msg !== '0) begin
            errors++;
            $display("FAIL iso_hold[%0d]: msg=%0h addr=%0h resp=%0h, want 3/beef/0",
                     i, bus.down_msg_out, bus.down_address_out, bus.resp_msg);
         end
      end
      bus.down_msg_in = 3'd5;
      tick();
      bus.down_msg_in = '0;
      checks++;
      if (bus.resp_msg[0 +: MB] !== '0 || bus.resp_msg[MB +: MB] !== 3'd5) begin
         errors++;
         $display("FAIL iso_resp: resp_msg=%0h, want port1=5 port0=0", bus.resp_msg);
      end
      bus.req_msg[MB +: MB] = '0;
      tick();
      bus.req_msg[0 +: MB] = '0;
      tick();
   endtask

   task automatic test_random();
      int w;
      logic [NP-1:0]    mask;
      logic [MB-1:0]    e_msg, r_msg;
      logic [AW-1:0]    e_addr, r_addr;
      logic [BW-1:0]    e_data, r_data;
      logic [NP*MB-1:0] x_msg;
      logic [NP*AW-1:0] x_addr;
      logic [NP*BW-1:0] x_data;
      reset_dut();
      for (int t = 0; t < 30; t++) begin
         mask = req_mask();
         if (mask == '0) begin
            set_req($urandom_range(0, NP - 1), 3'($urandom_range(1, 7)), $urandom, rand_line());
            mask = req_mask();
         end
         w = rr_pick(m_last, mask);
         e_msg  = bus.req_msg[w*MB +: MB];
         e_addr = bus.req_address[w*AW +: AW];
         e_data = bus.req_data[w*BW +: BW];
         tick();
         checks++;
         if (busy !== 1'b1 || grant_id !== 2'(w) || bus.down_msg_out !== e_msg ||
             bus.down_address_out !== e_addr || bus.down_data_out !== e_data) begin
            errors++;
            $display("FAIL rand_grant[%0d]: gid=%0d msg=%0h addr=%0h, want %0d/%0h/%0h",
                     t, grant_id, bus.down_msg_out, bus.down_address_out, w, e_msg, e_addr);
         end
         repeat ($urandom_range(0, TO - 2)) begin
            for (int p = 0; p < NP; p++)
               set_req(p, (p == w) ? 3'($urandom_range(1, 7)) : 3'($urandom_range(0, 7)), $urandom, rand_line());
            tick();
            checks++;
            if (bus.down_msg_out !== e_msg || bus.down_address_out !== e_addr || bus.down_data_out !== e_data ||
                bus.resp_msg !== '0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL rand_hold[%0d]: msg=%0h addr=%0h resp=%0h, want %0h/%0h/0",
                        t, bus.down_msg_out, bus.down_address_out, bus.resp_msg, e_msg, e_addr);
            end
         end
         r_msg = 3'($urandom_range(1, 7)); r_addr = $urandom; r_data = rand_line();
         bus.down_msg_in = r_msg; bus.down_address_in = r_addr; bus.down_data_in = r_data;
         tick();
         x_msg = '0;  x_msg[w*MB +: MB] = r_msg;
         x_addr = '0; x_addr[w*AW +: AW] = r_addr;
         x_data = '0; x_data[w*BW +: BW] = r_data;
         checks++;
         if (bus.resp_msg !== x_msg || bus.resp_address !== x_addr || bus.resp_data !== x_data ||
             bus.down_msg_out !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rand_resp[%0d]: resp_msg=%0h down_msg=%0h, want %0h/0", t, bus.resp_msg, bus.down_msg_out, x_msg);
         end
         repeat ($urandom_range(0, 2)) begin
            bus.down_msg_in = 3'($urandom_range(0, 7)); bus.down_address_in = $urandom; bus.down_data_in = rand_line();
            tick();
            checks++;
            if (bus.resp_msg !== x_msg || bus.resp_address !== x_addr || bus.resp_data !== x_data) begin
               errors++;
               $display("FAIL rand_drain_hold[%0d]: resp_msg=%0h, want %0h", t, bus.resp_msg, x_msg);
            end
         end
         bus.down_msg_in = '0;
         bus.req_msg[w*MB +: MB] = '0;
         tick();
         checks++;
         if (bus.resp_msg !== '0 || bus.resp_data !== '0 || busy !== 1'b0 || grant_id !== 2'(w)) begin
            errors++;
            $display("FAIL rand_release[%0d]: resp_msg=%0h busy=%0b gid=%0d, want 0/0/%0d", t, bus.resp_msg, busy, grant_id, w);
         end
         m_last = w;
         for (int p = 0; p < NP; p++)
            if (bus.req_msg[p*MB +: MB] == '0 && $urandom_range(0, 1) == 1)
               set_req(p, 3'($urandom_range(1, 7)), $urandom, rand_line());
      end
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL rand_no_timeout: timeout_err=%0b, want 0", timeout_err);
      end
   endtask

   task automatic test_watchdog();
      reset_dut();
      set_req(1, 3'd2, 32'h100, rand_line());
      tick();
      repeat (TO - 1) tick();
      checks++;
      if (busy !== 1'b1 || timeout_err !== 1'b0 || bus.down_msg_out !== 3'd2) begin
         errors++;
         $display("FAIL wd_before_expiry: busy=%0b err=%0b msg=%0h, want 1/0/2", busy, timeout_err, bus.down_msg_out);
      end
      bus.down_msg_in = 3'd5;
      tick();
      bus.down_msg_in = '0;
      checks++;
      if (busy !== 1'b1 || timeout_err !== 1'b0 || bus.resp_msg[MB +: MB] !== 3'd5) begin
         errors++;
         $display("FAIL wd_resp_priority: busy=%0b err=%0b resp1=%0h, want 1/0/5", busy, timeout_err, bus.resp_msg[MB +: MB]);
      end
      bus.req_msg[MB +: MB] = '0;
      tick();
      set_req(0, 3'd3, 32'h200, rand_line());
      set_req(1, 3'd1, 32'h300, rand_line());
      tick();
      checks++;
      if (grant_id !== 2'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL wd_grant: gid=%0d busy=%0b, want 0/1", grant_id, busy);
      end
      repeat (TO - 1) tick();
      checks++;
      if (busy !== 1'b1 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL wd_early_abort: busy=%0b err=%0b, want 1/0", busy, timeout_err);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || timeout_err !== 1'b1 || bus.down_msg_out !== '0 || bus.resp_msg !== '0) begin
         errors++;
         $display("FAIL wd_abort: busy=%0b err=%0b msg=%0h resp=%0h, want 0/1/0/0",
                  busy, timeout_err, bus.down_msg_out, bus.resp_msg);
      end
      tick();
      checks++;
      if (grant_id !== 2'd1 || busy !== 1'b1 || bus.down_address_out !== 32'h300 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL wd_next_grant: gid=%0d busy=%0b addr=%0h err=%0b, want 1/1/300/1",
                  grant_id, busy, bus.down_address_out, timeout_err);
      end
      bus.down_msg_in = 3'd2;
      tick();
      bus.down_msg_in = '0;
      bus.req_msg = '0;
      tick();
   endtask

   task automatic test_reset_mid_op();
      reset_dut();
      set_req(3, 3'd1, 32'h33, rand_line());
      tick();
      bus.down_msg_in = 3'd4;
      tick();
      bus.down_msg_in = '0;
      checks++;
      if (bus.resp_msg[3*MB +: MB] !== 3'd4) begin
         errors++;
         $display("FAIL rst_pre_drain: resp3=%0h, want 4", bus.resp_msg[3*MB +: MB]);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, timeout_err, grant_id} !== 4'b0 || bus.resp_msg !== '0 || bus.resp_data !== '0 ||
          bus.down_msg_out !== '0) begin
         errors++;
         $display("FAIL rst_async: busy=%0b err=%0b gid=%0d resp=%0h, want all 0", busy, timeout_err, grant_id, bus.resp_msg);
      end
      tick();
      reset = 1'b1;
      m_last = NP - 1;
      clear_inputs();
      for (int p = 0; p < NP; p++) set_req(p, 3'd1, 32'(p), rand_line());
      tick();
      checks++;
      if (grant_id !== 2'(rr_pick(m_last, req_mask())) || busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_first_winner: gid=%0d busy=%0b, want 0/1", grant_id, busy);
      end
   endtask

   task automatic test_back_to_back();
      int w;
      reset_dut();
      bus2.req_msg = {3'd2, 3'd1};
      bus2.req_address = {32'h22, 32'h11};
      for (int i = 0; i < 6; i++) begin
         w = i % 2;
         tick();
         checks++;
         if (g2_id !== 1'(w) || g2_busy !== 1'b1 || bus2.down_address_out !== ((w == 1) ? 32'h22 : 32'h11)) begin
            errors++;
            $display("FAIL b2b_grant[%0d]: gid=%0d busy=%0b addr=%0h, want %0d/1", i, g2_id, g2_busy, bus2.down_address_out, w);
         end
         bus2.down_msg_in = 3'd7;
         tick();
         bus2.down_msg_in = '0;
         bus2.req_msg[w*MB +: MB] = '0;
         tick();
         checks++;
         if (g2_busy !== 1'b0 || bus2.resp_msg !== '0) begin
            errors++;
            $display("FAIL b2b_release[%0d]: busy=%0b resp=%0h, want 0/0", i, g2_busy, bus2.resp_msg);
         end
         bus2.req_msg[w*MB +: MB] = 3'(w + 1);
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_isolation();
      test_random();
      test_watchdog();
      test_reset_mid_op();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
